divider_taint_track_bitwise: RTL and testbench
==============================================

// Module: divider_taint_track_bitwise
// PURPOSE
//  Constant-time sequential restoring divider with 1-bit-per-bus taint tracking; inverse companion of the shift-add multiplier.
//  Always takes exactly WIDTH iteration cycles regardless of operand values, so timing leaks nothing; taint outputs flag any result derived from tainted data or control.
//  Sits beside the multiplier in the constant-time taint-tracking arithmetic set.
// PARAMETERS
//  WIDTH  4  operand width in bits (dividend, divisor, quotient, remainder)
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request new division; sampled only in IDLE or DONE
//  start_t     in   1      taint of start
//  dividend    in   WIDTH  numerator, captured when start accepted
//  dividend_t  in   1      taint of dividend bus
//  divisor     in   WIDTH  denominator, captured when start accepted
//  divisor_t   in   1      taint of divisor bus
//  quotient    out  WIDTH  result quotient, held until next accepted start
//  quotient_t  out  1      taint of quotient
//  remainder   out  WIDTH  result remainder, held until next accepted start
//  remainder_t out  1      taint of remainder
//  quotientDone   out 1    one-cycle pulse: results valid
//  quotientDone_t out 1    taint of quotientDone
// BEHAVIOUR
//  Reset: state=IDLE, count=0, quotient=0, remainder=0, all *_t=0, quotientDone=0.
//  States: IDLE -> ITER (start=1) ; ITER -> ITER while count<WIDTH-1 ; ITER -> DONE at count=WIDTH-1 ;
//   DONE -> ITER (start=1) else DONE -> IDLE. DONE lasts one cycle; quotientDone=1 only in DONE.
//  Accept edge: dividend/divisor latched, rem=0 (WIDTH+1 bits), q=dividend, count=0.
//  Each ITER edge: {rem,q} <<= 1; trial = rem - {1'b0,divisor}; if trial[WIDTH]==0 then rem=trial, q[0]=1.
//   Trial subtraction is computed every cycle; no early exit, no operand-dependent skips.
//  Latency: start sampled at edge N -> quotientDone=1 during cycle after edge N+WIDTH (WIDTH+1 cycles).
//  quotient/remainder outputs update only on the DONE-entry edge; stable otherwise.
//  Divide by zero: no special case; restoring algorithm yields quotient=all ones, remainder=dividend.
//  start while in ITER: ignored, no effect on operation or taint.
//  start and rst same cycle: rst wins.
//  rst mid-operation: abort, return to IDLE with reset values next cycle; no quotientDone pulse.
//  Taint (1 bit per bus, sticky per operation):
//   dataT  <= dividend_t | divisor_t at accept; ctrlT <= start_t at accept.
//   Taint-tracked control: start_t in IDLE/DONE marks the decision itself tainted, so ctrlT also sets
//   if start_t=1 in IDLE/DONE even when start=0 (whether an op began is secret).
//   quotient_t = remainder_t = dataT | ctrlT, updated with results on DONE entry.
//   quotientDone_t = ctrlT (constant time: operand taint never reaches done).
//   ctrlT/dataT clear only on rst or next untainted accept.
// STRUCTURE
//  Shared header divider_defs.vh: state encodings (IDLE, ITER, DONE), state width, count width = clog2(WIDTH).
//  Sub-module divider_datapath_taint_track_1bit: rem/q/divisor registers, trial subtractor, dataT.
//  Top holds control FSM, counter, ctrlT; control signals (ld, shift, wr_out) each carry a _t companion.
// TESTING (WIDTH=4)
//  13/3, no taint -> quotient=4, remainder=1, quotientDone pulse exactly 5 cycles after start edge, all _t=0.
//  15/1 and 2/9 -> (15,0) and (0,2); identical latency to case 1 (constant time check).
//  7/0 -> quotient=4'hF, remainder=7, same latency, no hang.
//  dividend_t=1, 13/3 -> quotient_t=remainder_t=1, quotientDone_t=0; next op with no taint -> all _t=0.
//  start_t=1 -> quotientDone_t=1, quotient_t=1; start pulsed mid-ITER -> ignored, result unchanged.
//  rst asserted at 2nd ITER cycle -> IDLE next cycle, outputs 0, no done pulse; new start completes normally.

Source files
------------

// File: rtl/divider_taint_track_bitwise_pkg.sv
// Shared definitions for the constant-time taint-tracking divider.
package divider_taint_track_bitwise_pkg;

   // Control FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StIter = 2'd1,
      StDone = 2'd2
   } state_e;

   // Iteration counter width; kept at least one bit for degenerate widths.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/divider_taint_track_bitwise_datapath.sv
// Restoring-division datapath: remainder/quotient/divisor registers, the trial
// subtractor evaluated every cycle, the result registers and the data taint bit.
module divider_taint_track_bitwise_datapath #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             shift,
   input  logic             shift_t,
   input  logic             wr_out,
   input  logic             wr_out_t,
   input  logic [WIDTH-1:0] dividend,
   input  logic             dividend_t,
   input  logic [WIDTH-1:0] divisor,
   input  logic             divisor_t,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             res_t
);

   // The working remainder never exceeds the divisor, so WIDTH bits hold it;
   // the extra bit only exists on the shifted value feeding the subtractor.
   logic [WIDTH-1:0] rem_q, q_q, div_q;
   logic [WIDTH-1:0] quot_out_q, rem_out_q;
   logic             data_t_q, res_t_q;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] q_sh, rem_nx, q_nx;

   // One restoring step; the subtraction is always performed so timing is flat.
   always_comb begin
      rem_sh = {rem_q, q_q[WIDTH-1]};
      q_sh   = q_q << 1;
      trial  = rem_sh - {1'b0, div_q};
      rem_nx = rem_sh[WIDTH-1:0];
      q_nx   = q_sh;
      if (!trial[WIDTH]) begin
         rem_nx = trial[WIDTH-1:0];
         q_nx   = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Working registers, result registers and data taint.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q      <= '0;
         q_q        <= '0;
         div_q      <= '0;
         data_t_q   <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         res_t_q    <= 1'b0;
      end else begin
         if (ld) begin
            div_q    <= divisor;
            rem_q    <= '0;
            q_q      <= dividend;
            data_t_q <= dividend_t | divisor_t;
         end else if (shift) begin
            rem_q <= rem_nx;
            q_q   <= q_nx;
         end
         // Results take the final step's values on the same edge it completes.
         if (wr_out) begin
            quot_out_q <= q_nx;
            rem_out_q  <= rem_nx;
            res_t_q    <= data_t_q | shift_t | wr_out_t;
         end
      end
   end

   assign quotient  = quot_out_q;
   assign remainder = rem_out_q;
   assign res_t     = res_t_q;

endmodule

// File: rtl/divider_taint_track_bitwise.sv
// Constant-time sequential restoring divider with one taint bit per bus.
// Top holds the control FSM, iteration counter and control taint.
module divider_taint_track_bitwise
   import divider_taint_track_bitwise_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             start_t,
   input  logic [WIDTH-1:0] dividend,
   input  logic             dividend_t,
   input  logic [WIDTH-1:0] divisor,
   input  logic             divisor_t,
   output logic [WIDTH-1:0] quotient,
   output logic             quotient_t,
   output logic [WIDTH-1:0] remainder,
   output logic             remainder_t,
   output logic             quotientDone,
   output logic             quotientDone_t
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ctrl_t_q, ctrl_t_d;
   logic            ld, ld_t, shift, shift_t, wr_out, wr_out_t;
   logic            res_t;

   // Control signal taints: loading follows start_t, everything after follows ctrlT.
   assign ld_t     = start_t;
   assign shift_t  = ctrl_t_q;
   assign wr_out_t = ctrl_t_q;

   // State, counter and control taint registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ctrl_t_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ctrl_t_q <= ctrl_t_d;
      end
   end

   // Next-state and control decode; the iteration count never depends on operands.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ctrl_t_d = ctrl_t_q;
      ld       = 1'b0;
      shift    = 1'b0;
      wr_out   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               ld       = 1'b1;
               state_d  = StIter;
               cnt_d    = '0;
               ctrl_t_d = ld_t;
            end else begin
               if (state_q == StDone) state_d = StIdle;
               // A tainted start line makes "did an op begin" secret.
               if (start_t) ctrl_t_d = 1'b1;
            end
         end
         StIter: begin
            shift = 1'b1;
            if (cnt_q == CntLast) begin
               wr_out  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   divider_taint_track_bitwise_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk        (clk),
      .rst        (rst),
      .ld         (ld),
      .shift      (shift),
      .shift_t    (shift_t),
      .wr_out     (wr_out),
      .wr_out_t   (wr_out_t),
      .dividend   (dividend),
      .dividend_t (dividend_t),
      .divisor    (divisor),
      .divisor_t  (divisor_t),
      .quotient   (quotient),
      .remainder  (remainder),
      .res_t      (res_t)
   );

   assign quotient_t     = res_t;
   assign remainder_t    = res_t;
   assign quotientDone   = (state_q == StDone);
   assign quotientDone_t = ctrl_t_q;

endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
// Self-checking bench for divider_taint_track_bitwise (WIDTH=4).
module tb_divider_taint_track_bitwise;

   localparam int unsigned W = 4;
   localparam int Latency = 4;  // accept edge N -> done visible after edge N+W

   logic         clk = 1'b0;
   logic         rst, start, start_t, dividend_t, divisor_t;
   logic [W-1:0] dividend, divisor;
   logic [W-1:0] quotient, remainder;
   logic         quotient_t, remainder_t, quotientDone, quotientDone_t;

   divider_taint_track_bitwise #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .start_t        (start_t),
      .dividend       (dividend),
      .dividend_t     (dividend_t),
      .divisor        (divisor),
      .divisor_t      (divisor_t),
      .quotient       (quotient),
      .quotient_t     (quotient_t),
      .remainder      (remainder),
      .remainder_t    (remainder_t),
      .quotientDone   (quotientDone),
      .quotientDone_t (quotientDone_t)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b;
      logic         at, bt, st;
      logic [W-1:0] q, r;
      logic         qt, dt;
   } vec_t;

   vec_t         vecs[8];
   vec_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] last_q = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one operation, push its expectation, wait (bounded) for done, compare.
   task automatic run_op(input vec_t v, input bit mid_start);
      vec_t e;
      int   lat = 0;
      start = 1'b1; start_t = v.st;
      dividend = v.a; dividend_t = v.at;
      divisor = v.b; divisor_t = v.bt;
      sb.push_back(v);
      @(posedge clk); #1;
      start = 1'b0; start_t = 1'b0; dividend_t = 1'b0; divisor_t = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (mid_start && k == 2) begin
            start = 1'b1; dividend = 4'hF; divisor = 4'h1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (k == 1) check("hold_q", quotient, last_q);
         if (quotientDone) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL timeout actual=no_done required=done");
      end else begin
         check("latency", lat, Latency);
         check("quotient", quotient, e.q);
         check("remainder", remainder, e.r);
         check("quotient_t", quotient_t, e.qt);
         check("remainder_t", remainder_t, e.qt);
         check("done_t", quotientDone_t, e.dt);
      end
      @(posedge clk); #1;
      check("pulse_one", quotientDone, 1'b0);
      last_q = e.q;
   endtask

   initial begin
      bit seen;
      vec_t h;
      //          a     b     at    bt    st    q     r     qt    dt
      vecs[0] = '{4'd13, 4'd3, 1'b0, 1'b0, 1'b0, 4'd4,  4'd1, 1'b0, 1'b0};
      vecs[1] = '{4'd15, 4'd1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0, 1'b0};
      vecs[2] = '{4'd2,  4'd9, 1'b0, 1'b0, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0};
      vecs[3] = '{4'd7,  4'd0, 1'b0, 1'b0, 1'b0, 4'hF,  4'd7, 1'b0, 1'b0};
      vecs[4] = '{4'd13, 4'd3, 1'b1, 1'b0, 1'b0, 4'd4,  4'd1, 1'b1, 1'b0};
      vecs[5] = '{4'd13, 4'd3, 1'b0, 1'b0, 1'b0, 4'd4,  4'd1, 1'b0, 1'b0};
      vecs[6] = '{4'd6,  4'd4, 1'b0, 1'b0, 1'b1, 4'd1,  4'd2, 1'b1, 1'b1};
      vecs[7] = '{4'd9,  4'd2, 1'b0, 1'b1, 1'b0, 4'd4,  4'd1, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; start_t = 1'b0;
      dividend = '0; divisor = '0; dividend_t = 1'b0; divisor_t = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_quotient_t", quotient_t, 0);
      check("rst_remainder_t", remainder_t, 0);
      check("rst_done", quotientDone, 0);
      check("rst_done_t", quotientDone_t, 0);

      for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

      // start pulsed mid-ITER is ignored.
      h = '{4'd13, 4'd3, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 1'b0, 1'b0};
      run_op(h, 1'b1);

      // start_t alone in IDLE taints the control decision.
      start_t = 1'b1;
      @(posedge clk); #1;
      start_t = 1'b0;
      check("idle_taint_done_t", quotientDone_t, 1'b1);
      check("idle_taint_done", quotientDone, 1'b0);
      check("idle_taint_quotient_t", quotient_t, 1'b0);
      h = '{4'd10, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0};
      run_op(h, 1'b0);

      // rst during the second ITER cycle aborts the operation.
      start = 1'b1; dividend = 4'd14; divisor = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_done", quotientDone, 0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (quotientDone) seen = 1'b1;
      end
      check("abort_no_done", seen, 1'b0);
      last_q = '0;
      h = '{4'd14, 4'd5, 1'b0, 1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0};
      run_op(h, 1'b0);

      // rst and start in the same cycle: reset wins.
      start = 1'b1; rst = 1'b1; dividend = 4'd9; divisor = 4'd2;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      check("rst_start_quotient", quotient, 0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (quotientDone) seen = 1'b1;
      end
      check("rst_start_no_done", seen, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
